// File: rtl/datapath_pkg.sv
// Shared datapath types for the scalar writeback path: request payload,
// source identifiers and the default ALU anti-starvation threshold.
package datapath_pkg;

    localparam int WB_REG_W        = 5;
    localparam int WB_DATA_W       = 32;
    localparam int WB_STARVE_LIMIT = 4;
    localparam int WB_CNT_W        = 4;

    typedef struct packed {
        logic [WB_REG_W-1:0]  rd;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        WB_SRC_LOAD = 1'b0,
        WB_SRC_ALU  = 1'b1
    } wb_src_e;

    function automatic logic [WB_CNT_W-1:0] sat_inc(input logic [WB_CNT_W-1:0] v);
        return (v == {WB_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a functional-unit result awaiting the
// register-file write port. A pop and a new accept may occur in the same cycle.
module wb_slot
    import datapath_pkg::*;
#(
    parameter type req_t = wb_req_t
) (
    input  logic CLK,
    input  logic RST,
    input  logic in_valid,
    output logic in_ready,
    input  req_t in_req,
    input  logic pop,
    output logic full,
    output req_t out_req
);

    logic full_q;
    req_t req_q;
    logic accept;

    // Ready is a function of slot state only, never of in_valid.
    assign in_ready = !RST && (!full_q || pop);
    assign accept   = in_valid && in_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            full_q <= 1'b0;
        end else if (accept) begin
            full_q <= 1'b1;
        end else if (pop) begin
            full_q <= 1'b0;
        end
    end

    // NOTE: the payload is not reset; full_q qualifies it, so resetting wide data only costs routing.
    always_ff @(posedge CLK) begin
        if (accept) begin
            req_q <= in_req;
        end
    end

    assign full    = full_q;
    assign out_req = req_q;

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates the scalar register-file write port between the load unit and the
// ALU: load-preferred priority with a saturating ALU starvation override.
module wb_arbiter
    import datapath_pkg::*;
#(
    parameter int REG_W        = WB_REG_W,
    parameter int DATA_W       = WB_DATA_W,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [REG_W-1:0]  load_rd,
    input  logic [DATA_W-1:0] load_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              load_done,
    output logic              alu_done
);

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } req_t;

    localparam logic [WB_CNT_W-1:0] LIMIT = WB_CNT_W'(STARVE_LIMIT);

    req_t    load_in, alu_in, load_req, alu_req, grant_req;
    logic    load_full, alu_full, load_pop, alu_pop;
    logic    grant_valid;
    wb_src_e grant_src;
    logic [WB_CNT_W-1:0] starve_cnt;

    assign load_in = '{rd: load_rd, data: load_data};
    assign alu_in  = '{rd: alu_rd,  data: alu_data};

    wb_slot #(.req_t(req_t)) u_load_slot (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (load_valid),
        .in_ready (load_ready),
        .in_req   (load_in),
        .pop      (load_pop),
        .full     (load_full),
        .out_req  (load_req)
    );

    wb_slot #(.req_t(req_t)) u_alu_slot (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (alu_valid),
        .in_ready (alu_ready),
        .in_req   (alu_in),
        .pop      (alu_pop),
        .full     (alu_full),
        .out_req  (alu_req)
    );

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = WB_SRC_LOAD;
        if (load_full && alu_full) begin
            grant_valid = 1'b1;
            grant_src   = (starve_cnt >= LIMIT) ? WB_SRC_ALU : WB_SRC_LOAD;
        end else if (load_full) begin
            grant_valid = 1'b1;
            grant_src   = WB_SRC_LOAD;
        end else if (alu_full) begin
            grant_valid = 1'b1;
            grant_src   = WB_SRC_ALU;
        end
    end

    assign load_pop  = grant_valid && (grant_src == WB_SRC_LOAD);
    assign alu_pop   = grant_valid && (grant_src == WB_SRC_ALU);
    assign grant_req = (grant_src == WB_SRC_ALU) ? alu_req : load_req;

    // Counts consecutive cycles the ALU waited while load won the port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve_cnt <= '0;
        end else if (!alu_full || alu_pop) begin
            starve_cnt <= '0;
        end else if (load_pop) begin
            starve_cnt <= sat_inc(starve_cnt);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_en     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            load_done <= 1'b0;
            alu_done  <= 1'b0;
        end else begin
            // x0 writes still retire (done pulses) but never enable the write.
            wb_en     <= grant_valid && (grant_req.rd != '0);
            load_done <= load_pop;
            alu_done  <= alu_pop;
            if (grant_valid) begin
                wb_rd   <= grant_req.rd;
                wb_data <= grant_req.data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a vector table for reset, single writes, x0
// and simple contention, plus sequences for streaming, drain and mid-op reset.
module tb_wb_arbiter;

    logic        CLK;
    logic        RST;
    logic        load_valid, load_ready;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        load_done, alu_done;

    int checks   = 0;
    int failures = 0;

    wb_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_rd    (load_rd),
        .load_data  (load_data),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .load_done  (load_done),
        .alu_done   (alu_done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic        rst;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        e_lr;
        logic        e_ar;
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_ld;
        logic        e_ad;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic lv, input logic [4:0] lrd,
                                input logic [31:0] ldata, input logic av, input logic [4:0] ard,
                                input logic [31:0] adata, input logic e_lr, input logic e_ar,
                                input logic e_en, input logic [4:0] e_rd, input logic [31:0] e_data,
                                input logic e_ld, input logic e_ad);
        vec_t v;
        v.rst = rst; v.lv = lv; v.lrd = lrd; v.ldata = ldata;
        v.av = av; v.ard = ard; v.adata = adata;
        v.e_lr = e_lr; v.e_ar = e_ar; v.e_en = e_en; v.e_rd = e_rd;
        v.e_data = e_data; v.e_ld = e_ld; v.e_ad = e_ad;
        return v;
    endfunction

    logic [36:0] lq[$];
    logic [36:0] aq[$];
    logic [36:0] exp_req;
    int          li, ai;
    logic        g_alu, acc_l, acc_a;

    initial begin
        //               rst lv lrd ldata          av ard adata     lr ar en rd wdata          ld ad
        vecs[0]  = mk(1, 1, 3, 32'h0000_AAAA, 1, 4, 32'hBBBB, 0, 0, 0, 0, 32'h0,          0, 0);
        vecs[1]  = mk(1, 1, 3, 32'h0000_AAAA, 1, 4, 32'hBBBB, 0, 0, 0, 0, 32'h0,          0, 0);
        vecs[2]  = mk(1, 1, 3, 32'h0000_AAAA, 1, 4, 32'hBBBB, 0, 0, 0, 0, 32'h0,          0, 0);
        vecs[3]  = mk(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 32'h0,    1, 1, 0, 0, 32'h0,          0, 0);
        vecs[4]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,    1, 1, 1, 5, 32'hDEAD_BEEF,  1, 0);
        vecs[5]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,    1, 1, 0, 5, 32'hDEAD_BEEF,  0, 0);
        vecs[6]  = mk(0, 0, 0, 32'h0,         1, 0, 32'h1234, 1, 1, 0, 5, 32'hDEAD_BEEF,  0, 0);
        vecs[7]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,    1, 1, 0, 0, 32'h1234,       0, 1);
        vecs[8]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,    1, 1, 0, 0, 32'h1234,       0, 0);
        vecs[9]  = mk(0, 1, 1, 32'h11,        1, 2, 32'h22,   1, 1, 0, 0, 32'h1234,       0, 0);
        vecs[10] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,    1, 0, 1, 1, 32'h11,         1, 0);
        vecs[11] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,    1, 1, 1, 2, 32'h22,         0, 1);
        vecs[12] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,    1, 1, 0, 2, 32'h22,         0, 0);

        // Table: inputs applied for one cycle, readies checked before the edge, outputs after it.
        for (int i = 0; i < 13; i++) begin
            RST = vecs[i].rst;
            load_valid = vecs[i].lv; load_rd = vecs[i].lrd; load_data = vecs[i].ldata;
            alu_valid  = vecs[i].av; alu_rd  = vecs[i].ard; alu_data  = vecs[i].adata;
            #1;
            check($sformatf("vec%0d_load_ready", i), load_ready, vecs[i].e_lr);
            check($sformatf("vec%0d_alu_ready", i),  alu_ready,  vecs[i].e_ar);
            @(posedge CLK);
            #1;
            check($sformatf("vec%0d_wb_en", i),     wb_en,     vecs[i].e_en);
            check($sformatf("vec%0d_wb_rd", i),     wb_rd,     vecs[i].e_rd);
            check($sformatf("vec%0d_wb_data", i),   wb_data,   vecs[i].e_data);
            check($sformatf("vec%0d_load_done", i), load_done, vecs[i].e_ld);
            check($sformatf("vec%0d_alu_done", i),  alu_done,  vecs[i].e_ad);
            @(negedge CLK);
        end

        // Contention: both sources stream; grant order must be L,L,L,L,A repeating.
        li = 0;
        ai = 0;
        for (int cyc = 0; cyc < 21; cyc++) begin
            g_alu = (cyc > 0) && (((cyc - 1) % 5) == 4);
            load_valid = 1'b1; load_rd = 5'((li % 31) + 1); load_data = 32'(32'h1000 + li);
            alu_valid  = 1'b1; alu_rd  = 5'((ai % 31) + 1); alu_data  = 32'(32'h2000 + ai);
            #1;
            check($sformatf("stream%0d_load_ready", cyc), load_ready, (cyc == 0) || !g_alu);
            check($sformatf("stream%0d_alu_ready", cyc),  alu_ready,  (cyc == 0) || g_alu);
            acc_l = load_ready;
            acc_a = alu_ready;
            @(posedge CLK);
            if (acc_l) begin lq.push_back({load_rd, load_data}); li++; end
            if (acc_a) begin aq.push_back({alu_rd, alu_data}); ai++; end
            #1;
            if (cyc == 0) begin
                check("stream0_wb_en", wb_en, 1'b0);
            end else begin
                check($sformatf("stream%0d_load_done", cyc), load_done, !g_alu);
                check($sformatf("stream%0d_alu_done", cyc),  alu_done,  g_alu);
                check($sformatf("stream%0d_wb_en", cyc),     wb_en,     1'b1);
                if (g_alu) begin
                    check($sformatf("stream%0d_alu_q_nonempty", cyc), aq.size() > 0, 1'b1);
                    exp_req = (aq.size() > 0) ? aq.pop_front() : '0;
                end else begin
                    check($sformatf("stream%0d_load_q_nonempty", cyc), lq.size() > 0, 1'b1);
                    exp_req = (lq.size() > 0) ? lq.pop_front() : '0;
                end
                check($sformatf("stream%0d_req", cyc), {wb_rd, wb_data}, exp_req);
            end
            @(negedge CLK);
        end

        // Drain: every outstanding result retires exactly once with its original value.
        load_valid = 1'b0;
        alu_valid  = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge CLK);
            #1;
            check($sformatf("drain%0d_one_done", cyc), load_done && alu_done, 1'b0);
            if (load_done) begin
                exp_req = (lq.size() > 0) ? lq.pop_front() : '0;
                check($sformatf("drain%0d_load_req", cyc), {wb_rd, wb_data}, exp_req);
            end
            if (alu_done) begin
                exp_req = (aq.size() > 0) ? aq.pop_front() : '0;
                check($sformatf("drain%0d_alu_req", cyc), {wb_rd, wb_data}, exp_req);
            end
            @(negedge CLK);
        end
        check("drain_load_q_empty", lq.size(), 0);
        check("drain_alu_q_empty",  aq.size(), 0);

        // Reset mid-operation: both slots full with a non-zero starvation count.
        load_valid = 1'b1; load_rd = 5'd9;  load_data = 32'h99;
        alu_valid  = 1'b1; alu_rd  = 5'd10; alu_data  = 32'hAA;
        @(posedge CLK);
        @(negedge CLK);
        load_rd = 5'd11; load_data = 32'hBB;
        alu_valid = 1'b0;
        @(posedge CLK);
        #1;
        check("midrst_pre_wb_rd", wb_rd, 5'd9);
        check("midrst_pre_cnt", dut.starve_cnt, 4'd1);
        @(negedge CLK);
        load_valid = 1'b0;
        RST = 1'b1;
        #1;
        check("midrst_load_ready", load_ready, 1'b0);
        check("midrst_alu_ready",  alu_ready,  1'b0);
        @(posedge CLK);
        #1;
        check("midrst_wb_en", wb_en, 1'b0);
        check("midrst_done", {load_done, alu_done}, 2'b00);
        check("midrst_cnt", dut.starve_cnt, 4'd0);
        check("midrst_wb_rd", wb_rd, 5'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(posedge CLK);
            #1;
            check($sformatf("postrst%0d_wb_en", cyc), wb_en, 1'b0);
            check($sformatf("postrst%0d_done", cyc), {load_done, alu_done}, 2'b00);
            @(negedge CLK);
        end
        load_valid = 1'b1; load_rd = 5'd7; load_data = 32'hCAFE_F00D;
        #1;
        check("fresh_load_ready", load_ready, 1'b1);
        @(posedge CLK);
        #1;
        check("fresh_accept_wb_en", wb_en, 1'b0);
        @(negedge CLK);
        load_valid = 1'b0;
        @(posedge CLK);
        #1;
        check("fresh_wb_en",     wb_en,     1'b1);
        check("fresh_wb_rd",     wb_rd,     5'd7);
        check("fresh_wb_data",   wb_data,   32'hCAFE_F00D);
        check("fresh_load_done", load_done, 1'b1);
        check("fresh_alu_done",  alu_done,  1'b0);
        @(posedge CLK);
        #1;
        check("fresh_after_wb_en", wb_en, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
